// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte stream, imem write port and status bundle of the boot loader
interface imem_boot_loader_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [11:0] imem_address;
  logic [31:0] imem_data;
  logic imem_wren;
  logic proc_reset;
  logic busy;
  logic done;
  logic error;
  logic [12:0] words_loaded;
  modport master (
    input in_data, in_valid,
    output in_ready, imem_address, imem_data, imem_wren, proc_reset, busy, done, error, words_loaded
  );
  modport slave (
    output in_data, in_valid,
    input in_ready, imem_address, imem_data, imem_wren, proc_reset, busy, done, error, words_loaded
  );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: writes a checksummed byte-stream image into imem, then releases proc_reset
module imem_boot_loader (
  input logic clock,
  input logic reset,
  imem_boot_loader_if.master bus
);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [2:0] IDLE = 3'd0, LEN_LO = 3'd1, LEN_HI = 3'd2, DATA = 3'd3,
                         WRITE = 3'd4, CSUM = 3'd5, DONE = 3'd6, ERROR = 3'd7;
  logic [2:0] state;
  logic [7:0] sum, len_lo;
  logic [12:0] len, k, n, k_next;
  logic [1:0] cnt;
  logic [31:0] word;
  logic fire;
  always_comb begin
    n = {bus.in_data[4:0], len_lo};
    k_next = k + 13'd1;
    fire = bus.in_valid && bus.in_ready;
  end
  // outputs decode from state alone, so reset drops an in-flight write at once
  assign bus.in_ready = state != WRITE && state != DONE;
  assign bus.imem_wren = state == WRITE;
  assign bus.imem_address = k[11:0];
  assign bus.imem_data = word;
  assign bus.proc_reset = state != DONE;
  assign bus.busy = state >= LEN_LO && state <= CSUM;
  assign bus.done = state == DONE;
  assign bus.error = state == ERROR;
  assign bus.words_loaded = k;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      sum <= 8'd0;
      len_lo <= 8'd0;
      len <= 13'd0;
      k <= 13'd0;
      cnt <= 2'd0;
      word <= 32'd0;
    end else
      case (state)
        IDLE, ERROR: if (fire && bus.in_data == SYNC_BYTE) begin
          state <= LEN_LO;
          sum <= 8'd0;
          k <= 13'd0;
        end
        LEN_LO: if (fire) begin
          len_lo <= bus.in_data;
          sum <= bus.in_data;
          state <= LEN_HI;
        end
        LEN_HI: if (fire) begin
          sum <= sum + bus.in_data;
          len <= n;
          cnt <= 2'd0;
          state <= (n == 13'd0 || n > 13'd4096) ? ERROR : DATA;
        end
        DATA: if (fire) begin
          sum <= sum + bus.in_data;
          word <= {bus.in_data, word[31:8]};
          cnt <= cnt + 2'd1;
          state <= cnt == 2'd3 ? WRITE : DATA;
        end
        WRITE: begin
          k <= k_next;
          state <= k_next == len ? CSUM : DATA;
        end
        CSUM: if (fire) state <= bus.in_data == sum ? DONE : ERROR;
        default: ;
      endcase
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed and randomized frames checked against a byte-level model of imem writes
module tb_imem_boot_loader;
  logic clock = 0;
  logic reset = 1;
  imem_boot_loader_if bus();
  imem_boot_loader dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int checks = 0, errors = 0, cyc = 0, rdy_bad = 0;
  logic [43:0] wlog[$];
  logic [7:0] dat[$], fq[$];
  always @(posedge clock) begin
    cyc++;
    if (bus.imem_wren) begin
      wlog.push_back({bus.imem_address, bus.imem_data});
      if (bus.in_ready) rdy_bad++;
    end
  end
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic build(int n, logic [7:0] delta, bit inc);
    logic [7:0] s, hi, b;
    dat.delete();
    fq.delete();
    hi = {3'($urandom), 5'(n >> 8)};
    fq.push_back(8'hA5);
    fq.push_back(8'(n));
    fq.push_back(hi);
    s = 8'(n) + hi;
    for (int i = 0; i < 4 * n; i++) begin
      b = inc ? 8'(i) : 8'($urandom);
      dat.push_back(b);
      fq.push_back(b);
      s += b;
    end
    fq.push_back(s + delta);
  endtask
  task automatic send(logic [7:0] b, int gap);
    int t = 0;
    repeat ($urandom_range(0, gap)) @(negedge clock);
    bus.in_data = b;
    bus.in_valid = 1;
    while (!bus.in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout observed in_ready 0 expected 1");
    end
    @(negedge clock);
    bus.in_valid = 0;
  endtask
  task automatic send_all(int cnt, int gap);
    for (int i = 0; i < cnt; i++) send(fq[i], gap);
  endtask
  task automatic check_writes(string tag, int n);
    int bad = 0;
    chk({tag, "_count"}, wlog.size(), n);
    for (int k = 0; k < n && k < wlog.size(); k++)
      if (wlog[k] !== {12'(k), dat[4*k+3], dat[4*k+2], dat[4*k+1], dat[4*k]}) bad++;
    chk({tag, "_words"}, bad, 0);
  endtask
  task automatic check_reset(string tag);
    chk({tag, "_flags"}, {bus.in_ready, bus.proc_reset, bus.imem_wren, bus.busy, bus.done, bus.error}, 6'b110000);
    chk({tag, "_addr"}, bus.imem_address, 0);
    chk({tag, "_data"}, bus.imem_data, 0);
    chk({tag, "_words"}, bus.words_loaded, 0);
  endtask
  task automatic do_reset;
    reset = 1;
    bus.in_valid = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    wlog.delete();
  endtask
  initial begin
    int c0, n;
    bit bad;
    bus.in_data = 0;
    bus.in_valid = 0;
    @(negedge clock);
    @(negedge clock);
    check_reset("por");
    reset = 0;
    wlog.delete();
    // directed frame at full input rate
    fq = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h26};
    dat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    rdy_bad = 0;
    c0 = cyc;
    send_all(12, 0);
    chk("a_cycles", cyc - c0, 14);
    check_writes("a", 2);
    chk("a_rdy_during_wr", rdy_bad, 0);
    chk("a_status", {bus.done, bus.error, bus.proc_reset, bus.busy, bus.in_ready}, 5'b10000);
    chk("a_words", bus.words_loaded, 2);
    // bad checksum, then recovery with the good frame
    do_reset();
    fq[11] = 8'h27;
    send_all(12, 0);
    check_writes("b", 2);
    chk("b_status", {bus.done, bus.error, bus.proc_reset}, 3'b011);
    fq[11] = 8'h26;
    wlog.delete();
    send(8'hA5, 0);
    chk("b_err_clear", {bus.error, bus.busy}, 2'b01);
    for (int i = 1; i < 12; i++) send(fq[i], 0);
    check_writes("b2", 2);
    chk("b2_status", {bus.done, bus.error, bus.proc_reset}, 3'b100);
    // leading junk and input gaps
    do_reset();
    send(8'h00, 3);
    send(8'hFF, 3);
    send(8'h13, 3);
    chk("c_idle", {bus.busy, bus.error, bus.in_ready}, 3'b001);
    build(1, 8'd0, 0);
    send_all(fq.size(), 3);
    check_writes("c", 1);
    chk("c_status", {bus.done, bus.error, bus.proc_reset}, 3'b100);
    // illegal lengths
    do_reset();
    fq = '{8'hA5, 8'h00, 8'h00};
    send_all(3, 0);
    chk("d_n0", {bus.error, bus.busy, bus.proc_reset}, 3'b101);
    fq = '{8'hA5, 8'h01, 8'h10};
    send_all(2, 0);
    chk("d_err_clear", bus.error, 0);
    send(fq[2], 0);
    chk("d_n4097", {bus.error, bus.busy, bus.proc_reset}, 3'b101);
    chk("d_no_write", wlog.size(), 0);
    // reset mid-frame, then resend
    do_reset();
    build(2, 8'd0, 0);
    send_all(9, 1);
    reset = 1;
    #1;
    check_reset("e_mid");
    @(negedge clock);
    reset = 0;
    wlog.delete();
    send_all(fq.size(), 1);
    check_writes("e", 2);
    chk("e_status", {bus.done, bus.error, bus.proc_reset}, 3'b100);
    // random frames, some with corrupted checksum
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = $urandom_range(1, 6);
      bad = 1'($urandom);
      build(n, bad ? 8'($urandom_range(1, 255)) : 8'd0, 0);
      send_all(fq.size(), 2);
      check_writes("f", n);
      chk("f_status", {bus.done, bus.error, bus.proc_reset}, bad ? 3'b011 : 3'b100);
      chk("f_words", bus.words_loaded, n);
    end
    // maximum length
    do_reset();
    build(4096, 8'd0, 1);
    send_all(fq.size(), 0);
    check_writes("g", 4096);
    chk("g_last_addr", wlog.size() > 0 ? 32'(wlog[wlog.size()-1][43:32]) : 32'hFFFFFFFF, 32'hFFF);
    chk("g_words", bus.words_loaded, 4096);
    chk("g_status", {bus.done, bus.error, bus.proc_reset}, 3'b100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
